// File: rtl/network.sv
// network: fixed-weight 8-4-4 MLP inference with one MAC per cycle and an argmax label output.
module network #(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int N_OUT = 4,
  parameter int ACC_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  output logic        done_port,
  output logic [31:0] return_port
);
  localparam int IW = $clog2(N_IN);
  localparam int HW = $clog2(N_HID);
  localparam int OW = $clog2(N_OUT);
  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_ARG, S_DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_i;
  logic [HW-1:0] r_j;
  logic [OW-1:0] r_k;
  logic signed [ACC_W-1:0] r_acc, r_best;
  logic signed [ACC_W-1:0] r_h [N_HID];
  logic signed [ACC_W-1:0] r_y [N_OUT];
  logic [OW-1:0] r_best_idx;
  logic [31:0] r_ret;
  logic signed [7:0] w_x [N_IN];
  logic signed [7:0] w_w1 [N_HID][N_IN];
  logic signed [7:0] w_w2 [N_OUT][N_HID];
  logic signed [ACC_W-1:0] w_ma, w_mb, w_sum, w_best;
  logic [OW-1:0] w_best_idx;
  logic w_last_i, w_last_j, w_last_k;
  always_comb begin
    for (int i = 0; i < N_IN; i++) w_x[i] = 8'(i - 4);
    for (int j = 0; j < N_HID; j++)
      for (int i = 0; i < N_IN; i++) w_w1[j][i] = 8'((i + 3 * j) % 7 - 3);
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < N_HID; j++) w_w2[k][j] = 8'((j + 2 * k) % 5 - 2);
  end
  // The single multiplier is shared: input x hidden weights in L1, hidden activations x output weights in L2.
  assign w_ma = r_state == S_L1 ? ACC_W'(w_w1[r_j][r_i]) : ACC_W'(w_w2[r_k][r_j]);
  assign w_mb = r_state == S_L1 ? ACC_W'(w_x[r_i]) : r_h[r_j];
  assign w_sum = r_acc + w_ma * w_mb;
  assign w_last_i = r_i == IW'(N_IN - 1);
  assign w_last_j = r_j == HW'(N_HID - 1);
  assign w_last_k = r_k == OW'(N_OUT - 1);
  network_argmax #(.ACC_W(ACC_W), .IW(OW)) u_arg (
    .i_first   (r_k == '0),
    .i_val     (r_y[r_k]),
    .i_idx     (r_k),
    .i_best    (r_best),
    .i_best_idx(r_best_idx),
    .o_best    (w_best),
    .o_best_idx(w_best_idx)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start_port ? S_L1 : S_IDLE;
      S_L1:    w_next = w_last_i && w_last_j ? S_L2 : S_L1;
      S_L2:    w_next = w_last_j && w_last_k ? S_ARG : S_L2;
      S_ARG:   w_next = w_last_k ? S_DONE : S_ARG;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_acc <= '0;
      r_best <= '0;
      r_best_idx <= '0;
      r_ret <= '0;
      for (int j = 0; j < N_HID; j++) r_h[j] <= '0;
      for (int k = 0; k < N_OUT; k++) r_y[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        S_L1: begin
          r_acc <= w_last_i ? '0 : w_sum;
          r_i <= w_last_i ? '0 : r_i + IW'(1);
          if (w_last_i) begin
            r_h[r_j] <= w_sum[ACC_W-1] ? '0 : w_sum;
            r_j <= w_last_j ? '0 : r_j + HW'(1);
          end
        end
        S_L2: begin
          r_acc <= w_last_j ? '0 : w_sum;
          r_j <= w_last_j ? '0 : r_j + HW'(1);
          if (w_last_j) begin
            r_y[r_k] <= w_sum;
            r_k <= w_last_k ? '0 : r_k + OW'(1);
          end
        end
        S_ARG: begin
          r_best <= w_best;
          r_best_idx <= w_best_idx;
          r_k <= w_last_k ? '0 : r_k + OW'(1);
          if (w_last_k) r_ret <= 32'(w_best_idx);
        end
        default: ;
      endcase
    end
  end
  assign done_port = r_state == S_DONE;
  assign return_port = r_ret;
endmodule

// Strict greater-than keeps the earlier index on ties.
module network_argmax #(
  parameter int ACC_W = 32,
  parameter int IW    = 2
) (
  input  logic                    i_first,
  input  logic signed [ACC_W-1:0] i_val,
  input  logic [IW-1:0]           i_idx,
  input  logic signed [ACC_W-1:0] i_best,
  input  logic [IW-1:0]           i_best_idx,
  output logic signed [ACC_W-1:0] o_best,
  output logic [IW-1:0]           o_best_idx
);
  logic w_take;
  assign w_take = i_first || i_val > i_best;
  assign o_best = w_take ? i_val : i_best;
  assign o_best_idx = w_take ? i_idx : i_best_idx;
endmodule

// File: tb/tb_network.sv
// tb_network: checks the network against a cycle-count/arithmetic reference model plus directed corner cases.
module tb_network;
  localparam int NI = 8, NH = 4, NO = 4;
  logic clock = 0, reset = 1, start_port = 0;
  logic done_port;
  logic [31:0] return_port;
  int tests = 0, fails = 0;
  network dut (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_port),
    .done_port  (done_port),
    .return_port(return_port)
  );
  logic a_first;
  logic signed [31:0] a_val, a_best, a_obest;
  logic [1:0] a_idx, a_bidx, a_obidx;
  network_argmax #(.ACC_W(32), .IW(2)) u_arg (
    .i_first   (a_first),
    .i_val     (a_val),
    .i_idx     (a_idx),
    .i_best    (a_best),
    .i_best_idx(a_bidx),
    .o_best    (a_obest),
    .o_best_idx(a_obidx)
  );
  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: network values from the weight formulas, timing as "busy for the total MAC+compare count".
  int m_h[NH], m_y[NO], m_lab;
  int m_ph = 0, m_rem = 0, m_ret = 0;
  bit chk_en = 0;

  function automatic int ref_argmax(input int v[NO]);
    int b = 0;
    for (int k = 1; k < NO; k++) if (v[k] > v[b]) b = k;
    return b;
  endfunction

  task automatic build_ref();
    for (int j = 0; j < NH; j++) begin
      int s = 0;
      for (int i = 0; i < NI; i++) s += (((i + 3 * j) % 7) - 3) * (i - 4);
      m_h[j] = s < 0 ? 0 : s;
    end
    for (int k = 0; k < NO; k++) begin
      m_y[k] = 0;
      for (int j = 0; j < NH; j++) m_y[k] += (((j + 2 * k) % 5) - 2) * m_h[j];
    end
    m_lab = ref_argmax(m_y);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_rem = 0; m_ret = 0;
    end else if (m_ph == 0) begin
      if (start_port) begin m_ph = 1; m_rem = NI * NH + NO * NH + NO; end
    end else if (m_ph == 1) begin
      m_rem--;
      if (m_rem == 0) begin m_ph = 2; m_ret = m_lab; end
    end else m_ph = 0;
  end

  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      chk("model_done", done_port, m_ph == 2);
      chk("model_ret", return_port, m_ret);
    end
  end

  task automatic run_inf(input int hold, input bit glitch, output int lat, output int ret);
    @(negedge clock);
    start_port = 1;
    @(posedge clock);
    lat = 0;
    ret = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (done_port) begin lat = c; ret = int'(return_port); break; end
      start_port = glitch ? 1'($urandom % 2) : (c < hold);
    end
    start_port = 0;
    repeat (2) @(negedge clock);
  endtask

  typedef struct {int gap; int hold; bit glitch; int exp_lat; int exp_ret;} vec_t;
  vec_t vt[6];

  typedef struct {int v0; int v1; int v2; int v3; int exp_lab;} avec_t;
  avec_t at[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ret, last, npulse, bad;
    build_ref();
    vt[0] = '{0, 1, 1'b0, 53, 1};
    vt[1] = '{3, 5, 1'b0, 53, 1};
    vt[2] = '{7, 40, 1'b0, 53, 1};
    vt[3] = '{0, 60, 1'b0, 53, 1};
    vt[4] = '{2, 20, 1'b1, 53, 1};
    vt[5] = '{5, 53, 1'b1, 53, 1};
    at[0] = '{5, 5, 5, 5, 0};
    at[1] = '{1, 7, 7, 3, 1};
    at[2] = '{-5, -2, -9, -2, 1};
    repeat (3) @(negedge clock);
    chk("reset_done", done_port, 0);
    chk("reset_ret", return_port, 0);
    chk("reset_acc", longint'(dut.r_acc), 0);
    for (int j = 0; j < NH; j++) chk("reset_h", longint'(dut.r_h[j]), 0);
    reset = 0;
    chk_en = 1;
    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (done_port || return_port != 0) bad++;
    end
    chk("idle_hold_activity", bad, 0);
    run_inf(1, 0, lat, ret);
    chk("nominal_latency", lat, 53);
    chk("nominal_label", ret, 1);
    for (int j = 0; j < NH; j++) chk("nominal_h", longint'(dut.r_h[j]), m_h[j]);
    for (int k = 0; k < NO; k++) chk("nominal_y", longint'(dut.r_y[k]), m_y[k]);
    foreach (vt[v]) begin
      repeat (vt[v].gap) @(negedge clock);
      run_inf(vt[v].hold, vt[v].glitch, lat, ret);
      chk("vec_latency", lat, vt[v].exp_lat);
      chk("vec_label", ret, vt[v].exp_ret);
    end
    @(negedge clock);
    start_port = 1;
    last = -1;
    npulse = 0;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clock);
      if (done_port) begin
        if (last < 0) chk("cont_first_latency", c, 53);
        else chk("cont_period", c - last, 54);
        chk("cont_label", return_port, 1);
        last = c;
        npulse++;
      end
    end
    start_port = 0;
    chk("cont_pulses", npulse, 9);
    repeat (60) @(negedge clock);
    start_port = 1;
    @(posedge clock);
    @(negedge clock);
    start_port = 0;
    repeat (19) @(negedge clock);
    reset = 1;
    #1;
    chk("midreset_done", done_port, 0);
    chk("midreset_ret", return_port, 0);
    chk("midreset_acc", longint'(dut.r_acc), 0);
    @(negedge clock);
    reset = 0;
    npulse = 0;
    repeat (80) begin
      @(negedge clock);
      if (done_port) npulse++;
    end
    chk("midreset_no_done", npulse, 0);
    chk("midreset_ret_hold", return_port, 0);
    run_inf(1, 0, lat, ret);
    chk("after_reset_latency", lat, 53);
    chk("after_reset_label", ret, 1);
    repeat (3000) begin
      @(negedge clock);
      start_port = ($urandom % 3) == 0;
      reset = ($urandom % 400) == 0;
    end
    @(negedge clock);
    reset = 0;
    start_port = 0;
    repeat (60) @(negedge clock);
    foreach (at[t]) begin
      int vals[NO];
      vals = '{at[t].v0, at[t].v1, at[t].v2, at[t].v3};
      a_best = 0;
      a_bidx = 0;
      for (int k = 0; k < NO; k++) begin
        a_first = k == 0;
        a_val = vals[k];
        a_idx = 2'(k);
        #1;
        a_best = a_obest;
        a_bidx = a_obidx;
      end
      chk("argmax_unit", a_bidx, at[t].exp_lab);
    end
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/network.md
NETWORK -- requirements
Module: network

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N_IN, 8, input vector length.
- N_HID, 4, hidden-layer neuron count.
- N_OUT, 4, output neuron count, i.e. number of class labels.
- ACC_W, 32, signed accumulator width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- start_port, input, 1, request one inference; sampled only in IDLE.
- done_port, output, 1, one-cycle completion pulse.
- return_port, output, 32, predicted label, zero-extended.
REQ-003 The design SHALL use one clock. Reset SHALL be asynchronous and active-high.

Function
REQ-004 Input vector SHALL be a constant ROM: x[i] = i - 4 for i = 0..N_IN-1, signed 8-bit.
REQ-005 Hidden weights SHALL be a constant ROM: W1[j][i] = ((i + 3*j) mod 7) - 3, signed 8-bit. Hidden biases SHALL be 0.
REQ-006 Output weights SHALL be a constant ROM: W2[k][j] = ((j + 2*k) mod 5) - 2, signed 8-bit. Output biases SHALL be 0.
REQ-007 Hidden layer SHALL compute h[j] = ReLU(sum_i W1[j][i]*x[i]):
- ACC_W-bit signed accumulation.
- Negative sums clamp to 0.
- Results stored in an N_HID-entry register array.
REQ-008 Output layer SHALL compute y[k] = sum_j W2[k][j]*h[j], ACC_W-bit signed, with no activation.
REQ-009 Label SHALL be argmax_k y[k] using signed compare. On a tie, the lowest index wins.
REQ-010 Datapath SHALL use exactly one multiply-accumulate per clock cycle.
REQ-011 FSM states and transitions:
- IDLE: go to L1 when start_port=1 is sampled; clear the accumulator and indices.
- L1: N_IN*N_HID cycles. Each neuron's activation is written on its last MAC, then the accumulator clears.
- L2: N_OUT*N_HID cycles. Each y[k] is written on its last MAC.
- ARGMAX: N_OUT cycles, one compare per cycle.
- DONE: 1 cycle, then return to IDLE.
REQ-012 Latency: with defaults, done_port SHALL be high during the 53rd cycle after the sampling edge (edge 0):
- edges 1-32: L1
- edges 33-48: L2
- edges 49-52: ARGMAX
- edge 52 enters DONE
REQ-013 done_port SHALL be high only while in DONE, for exactly one clock cycle per inference.
REQ-014 return_port SHALL be loaded on the edge entering DONE and SHALL hold that value until the next DONE or reset.
REQ-015 start_port SHALL be ignored outside IDLE. No queuing or restart occurs mid-computation.
REQ-016 If start_port remains high after DONE, a new inference SHALL begin from the following IDLE cycle and give the identical result.
REQ-017 Accumulation SHALL NOT overflow at default sizes. Magnitudes are bounded well below 2^31.

Reset
REQ-018 While reset=1, the design SHALL hold:
- FSM state = IDLE
- done_port = 0
- return_port = 0
- accumulator, indices, h[] and y[] = 0
REQ-019 Assertion of reset mid-computation SHALL abort immediately, with no done pulse, and leave return_port at 0.
REQ-020 After reset deasserts, the first rising edge with start_port=1 SHALL be the sampling edge.

Verification
REQ-021 Nominal run:
- Stimulus: reset pulse, then start_port held at 1.
- Required: done_port pulses once at 53 cycles; return_port = 1.
- Intermediate values: h = [19,0,16,0]; y = [-38,32,22,-3].
REQ-022 Continuous start:
- Stimulus: start_port held at 1 for 500 cycles.
- Required: done pulses are periodic every 54 cycles, each exactly 1 cycle wide; return_port stays 1.
REQ-023 Idle hold:
- Stimulus: start_port = 0 after reset, for 200 cycles.
- Required: done_port = 0 and return_port = 0 throughout.
REQ-024 Reset mid-run:
- Stimulus: assert reset in cycle 20 of L1, then release.
- Required: outputs 0 immediately, no done pulse; a fresh start gives return_port = 1 after 53 cycles.
REQ-025 Start glitch while busy:
- Stimulus: toggle start_port during L1/L2.
- Required: latency stays 53 and a single done pulse occurs.
REQ-026 Tie-break:
- Stimulus: force y = [5,5,5,5] in a unit test of the ARGMAX stage.
- Required: label = 0.
